mpu_shift_ctrl: RTL and testbench

Parametrised shift-chain controller for the MPU accumulator array. It sequences three phases: loading C rows into the array, outer-product accumulation of A/B beats, and draining result rows back out. Compared with the previous controller, it adds stall-safe row counting, explicit ready/valid handshakes, and an end-of-operation marker. It also adds an optional overlapped drain/load mode, where the next C tile shifts in while results shift out. It sits between the MPU issue queue and the array datapath, and drives the per-phase shift enables.

---
 rtl/mpu_shift_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mpu_shift_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_shift_ctrl.sv
// Shift-chain controller for the MPU accumulator array.
// Sequences C-row load, A/B outer-product accumulation and result drain, with
// stall-safe row/beat counting and an optional overlapped drain/load mode.
module mpu_shift_ctrl #(
  parameter int unsigned ML      = 4,
  parameter int unsigned KW      = 8,
  parameter int unsigned OVERLAP = 0,
  localparam int unsigned CW     = $clog2(ML)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_valid,
  output logic          c_ready,
  input  logic          ab_valid,
  input  logic          ab_last,
  output logic          ab_ready,
  output logic          d_valid,
  input  logic          d_ready,
  output logic          en_c,
  output logic          en_ab,
  output logic          en_d,
  output logic [CW-1:0] row_idx,
  output logic [KW-1:0] k_cnt,
  output logic          k_ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLdC   = 2'd1,
    StOpAcc = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [CW-1:0] LastRow = CW'(ML - 1);
  localparam logic [KW-1:0] KMax    = {KW{1'b1}};

  state_e        state_q, state_d;
  state_e        state_out;
  logic [CW-1:0] row_q, row_d;
  logic [KW-1:0] k_q, k_d;
  logic          ovf_q, ovf_d;

  // While reset is held the outputs decode as IDLE, so c_ready is already 1 and
  // nothing is enabled even before the first reset edge has landed.
  assign state_out = reset ? StIdle : state_q;

  // Moore readies (plus the overlapped cross-coupling) and the shift enables.
  always_comb begin
    c_ready  = 1'b0;
    ab_ready = 1'b0;
    d_valid  = 1'b0;
    en_c     = 1'b0;
    en_ab    = 1'b0;
    en_d     = 1'b0;
    unique case (state_out)
      StIdle, StLdC: begin
        c_ready = 1'b1;
        en_c    = c_valid;
      end
      StOpAcc: begin
        ab_ready = 1'b1;
        en_ab    = ab_valid;
      end
      StDrain: begin
        if (OVERLAP != 0) begin
          // c_ready sees only d_ready and d_valid only c_valid: no loop.
          c_ready = d_ready;
          d_valid = c_valid;
          en_c    = c_valid & d_ready;
          en_d    = c_valid & d_ready;
        end else begin
          d_valid = 1'b1;
          en_d    = d_ready;
        end
      end
      default: ;
    endcase
    if (reset) begin
      en_c  = 1'b0;
      en_ab = 1'b0;
      en_d  = 1'b0;
    end
  end

  // Next-state and counter updates, advanced only by accepted beats.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (en_c) begin
          state_d = StLdC;
          row_d   = CW'(1);
        end
      end
      StLdC: begin
        if (en_c) begin
          if (row_q == LastRow) begin
            state_d = StOpAcc;
            row_d   = '0;
            k_d     = '0;
            ovf_d   = 1'b0;
          end else begin
            row_d = row_q + CW'(1);
          end
        end
      end
      StOpAcc: begin
        if (en_ab) begin
          // Saturate rather than wrap; the lost increment is flagged.
          if (k_q == KMax) ovf_d = 1'b1;
          else             k_d   = k_q + KW'(1);
          if (ab_last) begin
            state_d = StDrain;
            row_d   = '0;
          end
        end
      end
      StDrain: begin
        if (en_d) begin
          if (row_q == LastRow) begin
            row_d = '0;
            if (OVERLAP != 0) begin
              // Next C tile has shifted in alongside the drain.
              state_d = StOpAcc;
              k_d     = '0;
              ovf_d   = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            row_d = row_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
    end
  end

  assign row_idx = row_q;
  assign k_cnt   = k_q;
  assign k_ovf   = ovf_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mpu_shift_ctrl.sv
// Bench for mpu_shift_ctrl: two instances (non-overlapped KW=8, overlapped KW=3)
// checked every cycle against a phase/count model, plus literal spot checks.
module tb_mpu_shift_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: ML=4, KW=8, OVERLAP=0
  logic       c_valid0 = 0, ab_valid0 = 0, ab_last0 = 0, d_ready0 = 0;
  logic       c_ready0, ab_ready0, d_valid0, en_c0, en_ab0, en_d0, k_ovf0, busy0;
  logic [1:0] row_idx0;
  logic [7:0] k_cnt0;
  // Instance 1: ML=4, KW=3, OVERLAP=1
  logic       c_valid1 = 0, ab_valid1 = 0, ab_last1 = 0, d_ready1 = 0;
  logic       c_ready1, ab_ready1, d_valid1, en_c1, en_ab1, en_d1, k_ovf1, busy1;
  logic [1:0] row_idx1;
  logic [2:0] k_cnt1;

  mpu_shift_ctrl #(.ML(4), .KW(8), .OVERLAP(0)) dut0 (
    .clk(clk), .reset(reset), .c_valid(c_valid0), .c_ready(c_ready0),
    .ab_valid(ab_valid0), .ab_last(ab_last0), .ab_ready(ab_ready0),
    .d_valid(d_valid0), .d_ready(d_ready0), .en_c(en_c0), .en_ab(en_ab0),
    .en_d(en_d0), .row_idx(row_idx0), .k_cnt(k_cnt0), .k_ovf(k_ovf0), .busy(busy0)
  );

  mpu_shift_ctrl #(.ML(4), .KW(3), .OVERLAP(1)) dut1 (
    .clk(clk), .reset(reset), .c_valid(c_valid1), .c_ready(c_ready1),
    .ab_valid(ab_valid1), .ab_last(ab_last1), .ab_ready(ab_ready1),
    .d_valid(d_valid1), .d_ready(d_ready1), .en_c(en_c1), .en_ab(en_ab1),
    .en_d(en_d1), .row_idx(row_idx1), .k_cnt(k_cnt1), .k_ovf(k_ovf1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 accumulating, 3 draining; rows = rows
  // moved in the current load/drain, k = accepted beats (saturating).
  typedef struct {
    int ph;
    int rows;
    int k;
    bit ovf;
  } mdl_t;

  mdl_t m0 = '{0, 0, 0, 1'b0};
  mdl_t m1 = '{0, 0, 0, 1'b0};

  function automatic void exp_out(input mdl_t m, input bit rst, input bit cv, input bit abv,
                                  input bit dr, input bit ov, output bit cr, output bit abr,
                                  output bit dv, output bit ec, output bit eab, output bit ed);
    cr = 0; abr = 0; dv = 0; ec = 0; eab = 0; ed = 0;
    if (rst) begin
      cr = 1;
    end else if (m.ph <= 1) begin
      cr = 1; ec = cv;
    end else if (m.ph == 2) begin
      abr = 1; eab = abv;
    end else if (ov) begin
      dv = cv; cr = dr; ec = cv && dr; ed = cv && dr;
    end else begin
      dv = 1; ed = dr;
    end
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit rst, input bit cv, input bit abv,
                                input bit abl, input bit dr, input int ml, input int kw,
                                input bit ov);
    mdl_t n = m;
    bit shift;
    if (rst) return '{0, 0, 0, 1'b0};
    if (m.ph == 0) begin
      if (cv) begin n.ph = 1; n.rows = 1; end
    end else if (m.ph == 1) begin
      if (cv) begin
        n.rows = m.rows + 1;
        if (n.rows == ml) begin n.ph = 2; n.rows = 0; n.k = 0; n.ovf = 0; end
      end
    end else if (m.ph == 2) begin
      if (abv) begin
        if (m.k == (1 << kw) - 1) n.ovf = 1;
        else n.k = m.k + 1;
        if (abl) begin n.ph = 3; n.rows = 0; end
      end
    end else begin
      shift = ov ? (cv && dr) : dr;
      if (shift) begin
        n.rows = m.rows + 1;
        if (n.rows == ml) begin
          n.rows = 0;
          n.ph = ov ? 2 : 0;
          if (ov) begin n.k = 0; n.ovf = 0; end
        end
      end
    end
    return n;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit cr, abr, dv, ec, eab, ed;
    exp_out(m0, reset, c_valid0, ab_valid0, d_ready0, 1'b0, cr, abr, dv, ec, eab, ed);
    check("c_ready0", c_ready0, cr);
    check("ab_ready0", ab_ready0, abr);
    check("d_valid0", d_valid0, dv);
    check("en_c0", en_c0, ec);
    check("en_ab0", en_ab0, eab);
    check("en_d0", en_d0, ed);
    check("busy0", busy0, m0.ph != 0);
    check("row_idx0", row_idx0, 32'(m0.rows));
    check("k_cnt0", k_cnt0, 32'(m0.k));
    check("k_ovf0", k_ovf0, m0.ovf);
    m0 = step(m0, reset, c_valid0, ab_valid0, ab_last0, d_ready0, 4, 8, 1'b0);

    exp_out(m1, reset, c_valid1, ab_valid1, d_ready1, 1'b1, cr, abr, dv, ec, eab, ed);
    check("c_ready1", c_ready1, cr);
    check("ab_ready1", ab_ready1, abr);
    check("d_valid1", d_valid1, dv);
    check("en_c1", en_c1, ec);
    check("en_ab1", en_ab1, eab);
    check("en_d1", en_d1, ed);
    check("busy1", busy1, m1.ph != 0);
    check("row_idx1", row_idx1, 32'(m1.rows));
    check("k_cnt1", k_cnt1, 32'(m1.k));
    check("k_ovf1", k_ovf1, m1.ovf);
    m1 = step(m1, reset, c_valid1, ab_valid1, ab_last1, d_ready1, 4, 3, 1'b1);
  end

  // Pulse counters for the literal checks.
  int nec0 = 0, ned0 = 0, njoint = 0;
  always @(negedge clk) begin
    if (en_c0) nec0++;
    if (en_d0) ned0++;
    if (en_c1 && en_d1) njoint++;
  end

  task automatic drive0(input bit cv, input bit abv, input bit abl, input bit dr);
    c_valid0 = cv; ab_valid0 = abv; ab_last0 = abl; d_ready0 = dr;
    @(posedge clk); #1;
  endtask

  task automatic drive1(input bit cv, input bit abv, input bit abl, input bit dr);
    c_valid1 = cv; ab_valid1 = abv; ab_last1 = abl; d_ready1 = dr;
    @(posedge clk); #1;
  endtask

  initial begin
    bit ld_pat[6] = '{1, 0, 1, 1, 0, 1};
    bit ab_pat[6] = '{1, 1, 0, 1, 1, 1};
    bit ov_pat[5] = '{1, 1, 0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("lit_rst_c_ready", c_ready0, 1);
    check("lit_rst_busy", busy0, 0);
    check("lit_rst_k", k_cnt0, 0);

    // Load with stalls
    nec0 = 0;
    foreach (ld_pat[i]) drive0(ld_pat[i], 0, 0, 0);
    check("lit_load_en_c_count", nec0, 4);
    check("lit_load_opacc", ab_ready0, 1);
    check("lit_load_row", row_idx0, 0);

    // Accumulate 5 beats with one bubble, last on the 5th
    foreach (ab_pat[i]) drive0(0, ab_pat[i], i == 5, 0);
    drive0(0, 0, 0, 0);
    check("lit_acc_k", k_cnt0, 5);
    check("lit_acc_drain", d_valid0, 1);

    // Drain back-pressure, then four consecutive shifts
    repeat (3) drive0(0, 0, 0, 0);
    check("lit_bp_row", row_idx0, 0);
    ned0 = 0;
    repeat (4) drive0(0, 0, 0, 1);
    check("lit_drain_count", ned0, 4);
    check("lit_drain_idle", busy0, 0);

    // Single-beat op, then reset mid-drain at row 2
    repeat (4) drive0(1, 0, 0, 0);
    drive0(0, 1, 1, 0);
    check("lit_single_k", k_cnt0, 1);
    repeat (2) drive0(0, 0, 0, 1);
    check("lit_mid_row", row_idx0, 2);
    c_valid0 = 0; ab_valid0 = 0; ab_last0 = 0; d_ready0 = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("lit_rstmid_row", row_idx0, 0);
    check("lit_rstmid_busy", busy0, 0);
    check("lit_rstmid_k", k_cnt0, 0);
    check("lit_rstmid_c_ready", c_ready0, 1);
    check("lit_rstmid_en_d", en_d0, 0);

    // Saturation on the KW=3 overlapped instance
    repeat (4) drive1(1, 0, 0, 0);
    repeat (7) drive1(0, 1, 0, 0);
    check("lit_sat7_k", k_cnt1, 7);
    check("lit_sat7_ovf", k_ovf1, 0);
    drive1(0, 1, 0, 0);
    check("lit_sat8_k", k_cnt1, 7);
    check("lit_sat8_ovf", k_ovf1, 1);
    drive1(0, 1, 1, 0);
    check("lit_sat9_ovf", k_ovf1, 1);

    // Overlapped drain/load with one c_valid bubble
    njoint = 0;
    foreach (ov_pat[i]) drive1(ov_pat[i], 0, 0, 1);
    check("lit_ov_shifts", njoint, 4);
    check("lit_ov_opacc", ab_ready1, 1);
    check("lit_ov_k", k_cnt1, 0);
    check("lit_ov_ovf", k_ovf1, 0);

    // Cross-coupled readies under one-sided stalls
    drive1(0, 1, 1, 0);
    repeat (2) drive1(1, 0, 0, 0);
    repeat (2) drive1(0, 0, 0, 1);
    check("lit_ov_stall_row", row_idx1, 0);
    repeat (4) drive1(1, 0, 0, 1);
    drive1(0, 0, 0, 0);
    check("lit_ov_tile2_opacc", ab_ready1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
